// File: rtl/ascon_aead_sequencer.sv
// Ascon-AEAD128 control sequencer: steps the single-round datapath one permutation
// round per cycle through init, associated data, message and finalisation.

package ascon_aead_sequencer_pkg;
   localparam int ROUND_WIDTH = 4;

   typedef enum logic [3:0] {
      AsconOp0 = 4'd0,  // plain permutation round
      AsconOp1 = 4'd1,  // load IV/key/nonce
      AsconOp2 = 4'd2,  // init end, AD follows
      AsconOp3 = 4'd3,  // init end, no AD (domain separation)
      AsconOp4 = 4'd4,  // absorb AD block
      AsconOp5 = 4'd5,  // last AD round with domain separation
      AsconOp6 = 4'd6,  // absorb/squeeze message block
      AsconOp7 = 4'd7,  // last message block plus key xor
      AsconOp8 = 4'd8   // final round, tag out
   } ascon_op_e;
endpackage

module ascon_aead_sequencer
   import ascon_aead_sequencer_pkg::*;
#(
   parameter int BLOCK_AW = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   ad_present_i,
   input  logic                   decrypt_i,
   input  logic                   di_valid_i,
   input  logic                   di_last_i,
   output logic                   di_ready_o,
   output ascon_op_e              op_o,
   output logic [ROUND_WIDTH-1:0] round_o,
   output logic                   decrypt_o,
   output logic [BLOCK_AW-1:0]    di_blk_no_o,
   output logic                   state_we_o,
   output logic                   do_valid_o,
   output logic                   tag_valid_o,
   output logic                   busy_o
);

   // Handshake: a block is consumed in exactly the cycles where di_valid_i and
   // di_ready_o are both high; di_ready_o only rises in WAIT_AD/WAIT_MSG, and
   // the accepted block's round runs in that same cycle.

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_WAIT_AD,
      ST_AD,
      ST_WAIT_MSG,
      ST_MSG,
      ST_FINAL
   } state_e;

   localparam logic [ROUND_WIDTH-1:0] RND_LAST  = ROUND_WIDTH'(11);
   localparam logic [ROUND_WIDTH-1:0] RND_ONE   = ROUND_WIDTH'(1);
   localparam logic [ROUND_WIDTH-1:0] RND_ABS   = ROUND_WIDTH'(4);
   localparam logic [ROUND_WIDTH-1:0] RND_AFTER = ROUND_WIDTH'(5);

   state_e                  state_q, state_d;
   logic [ROUND_WIDTH-1:0]  rnd_q, rnd_d;
   logic [BLOCK_AW-1:0]     blk_q, blk_d;
   logic                    ad_present_q, ad_present_d;
   logic                    decrypt_q, decrypt_d;
   logic                    ad_last_q, ad_last_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         rnd_q        <= '0;
         blk_q        <= '0;
         ad_present_q <= 1'b0;
         decrypt_q    <= 1'b0;
         ad_last_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rnd_q        <= rnd_d;
         blk_q        <= blk_d;
         ad_present_q <= ad_present_d;
         decrypt_q    <= decrypt_d;
         ad_last_q    <= ad_last_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rnd_d        = rnd_q;
      blk_d        = blk_q;
      ad_present_d = ad_present_q;
      decrypt_d    = decrypt_q;
      ad_last_d    = ad_last_q;
      op_o         = AsconOp0;
      round_o      = '0;
      state_we_o   = 1'b0;
      di_ready_o   = 1'b0;
      do_valid_o   = 1'b0;
      tag_valid_o  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               ad_present_d = ad_present_i;
               decrypt_d    = decrypt_i;
               rnd_d        = '0;
               blk_d        = '0;
               state_d      = ST_INIT;
            end
         end

         ST_INIT: begin
            state_we_o = 1'b1;
            round_o    = rnd_q;
            op_o       = (rnd_q == '0) ? AsconOp1 : AsconOp0;
            if (rnd_q == RND_LAST) begin
               op_o    = ad_present_q ? AsconOp2 : AsconOp3;
               state_d = ad_present_q ? ST_WAIT_AD : ST_WAIT_MSG;
               blk_d   = '0;
            end else begin
               rnd_d = rnd_q + RND_ONE;
            end
         end

         ST_WAIT_AD: begin
            if (di_valid_i) begin
               di_ready_o = 1'b1;
               state_we_o = 1'b1;
               round_o    = RND_ABS;
               op_o       = AsconOp4;
               ad_last_d  = di_last_i;
               rnd_d      = RND_AFTER;
               state_d    = ST_AD;
            end
         end

         ST_AD: begin
            state_we_o = 1'b1;
            round_o    = rnd_q;
            if (rnd_q == RND_LAST) begin
               // Domain separation lands on the final round of the last AD block.
               if (ad_last_q) begin
                  op_o    = AsconOp5;
                  state_d = ST_WAIT_MSG;
                  blk_d   = '0;
               end else begin
                  state_d = ST_WAIT_AD;
                  blk_d   = blk_q + BLOCK_AW'(1);
               end
            end else begin
               rnd_d = rnd_q + RND_ONE;
            end
         end

         ST_WAIT_MSG: begin
            if (di_valid_i) begin
               di_ready_o = 1'b1;
               state_we_o = 1'b1;
               do_valid_o = 1'b1;
               if (di_last_i) begin
                  round_o = '0;
                  op_o    = AsconOp7;
                  rnd_d   = RND_ONE;
                  state_d = ST_FINAL;
               end else begin
                  round_o = RND_ABS;
                  op_o    = AsconOp6;
                  rnd_d   = RND_AFTER;
                  state_d = ST_MSG;
               end
            end
         end

         ST_MSG: begin
            state_we_o = 1'b1;
            round_o    = rnd_q;
            if (rnd_q == RND_LAST) begin
               state_d = ST_WAIT_MSG;
               blk_d   = blk_q + BLOCK_AW'(1);
            end else begin
               rnd_d = rnd_q + RND_ONE;
            end
         end

         ST_FINAL: begin
            state_we_o = 1'b1;
            round_o    = rnd_q;
            if (rnd_q == RND_LAST) begin
               op_o        = AsconOp8;
               tag_valid_o = 1'b1;
               state_d     = ST_IDLE;
               blk_d       = '0;
            end else begin
               rnd_d = rnd_q + RND_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign decrypt_o   = decrypt_q;
   assign di_blk_no_o = blk_q;

endmodule

// File: tb/tb_ascon_aead_sequencer.sv
// Bench for ascon_aead_sequencer: a step-schedule model of the round sequence is
// compared every cycle against two instances (block counter widths 8 and 2).

module tb_ascon_aead_sequencer;
   import ascon_aead_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst, start, ad_present, decrypt, di_valid, di_last;

   logic                   ready_a, ready_w, dec_a, dec_w;
   ascon_op_e              op_a, op_w;
   logic [ROUND_WIDTH-1:0] rnd_a, rnd_w;
   logic [7:0]             blk_a;
   logic [1:0]             blk_w;
   logic                   we_a, we_w, dov_a, dov_w, tag_a, tag_w, busy_a, busy_w;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ascon_aead_sequencer #(.BLOCK_AW(8)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .ad_present_i(ad_present),
      .decrypt_i(decrypt), .di_valid_i(di_valid), .di_last_i(di_last),
      .di_ready_o(ready_a), .op_o(op_a), .round_o(rnd_a), .decrypt_o(dec_a),
      .di_blk_no_o(blk_a), .state_we_o(we_a), .do_valid_o(dov_a),
      .tag_valid_o(tag_a), .busy_o(busy_a)
   );

   ascon_aead_sequencer #(.BLOCK_AW(2)) dut_w (
      .clk_i(clk), .rst_i(rst), .start_i(start), .ad_present_i(ad_present),
      .decrypt_i(decrypt), .di_valid_i(di_valid), .di_last_i(di_last),
      .di_ready_o(ready_w), .op_o(op_w), .round_o(rnd_w), .decrypt_o(dec_w),
      .di_blk_no_o(blk_w), .state_we_o(we_w), .do_valid_o(dov_w),
      .tag_valid_o(tag_w), .busy_o(busy_w)
   );

   function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endfunction

   // ---------------- behavioural model: schedule of pending round steps -------------
   localparam int A_NONE = 0, A_WAIT_AD = 1, A_WAIT_AD_INC = 2,
                  A_WAIT_MSG_CLR = 3, A_WAIT_MSG_INC = 4, A_IDLE = 5;

   typedef struct {
      logic [3:0] op;
      int         rnd;
      int         after;
   } step_t;

   step_t exp_q[$];
   step_t s_cur;
   bit    m_busy = 0, m_dec = 0, m_ad = 0;
   int    m_wait = 0;   // 0 none, 1 waiting for AD block, 2 waiting for message block
   int    m_blk  = 0;

   logic [3:0] e_op;
   int         e_rnd;
   bit         e_we, e_ready, e_dov, e_tag;

   function void add_rounds(input int from, input int to, input logic [3:0] last_op,
                            input int after);
      for (int r = from; r <= to; r++)
         exp_q.push_back('{(r == to) ? last_op : 4'd0, r, (r == to) ? after : A_NONE});
   endfunction

   always @(negedge clk) begin
      if (checking) begin
         e_op = 4'd0; e_rnd = 0; e_we = 0; e_ready = 0; e_dov = 0; e_tag = 0;
         if (m_busy) begin
            if (exp_q.size() > 0) begin
               e_op = exp_q[0].op; e_rnd = exp_q[0].rnd; e_we = 1;
               e_tag = (exp_q[0].op == 4'd8);
            end else if (m_wait == 1 && di_valid) begin
               e_ready = 1; e_we = 1; e_op = 4'd4; e_rnd = 4;
            end else if (m_wait == 2 && di_valid) begin
               e_ready = 1; e_we = 1; e_dov = 1;
               e_op  = di_last ? 4'd7 : 4'd6;
               e_rnd = di_last ? 0 : 4;
            end
         end

         chk("op",    op_a,    e_op);     chk("op_w",    op_w,    e_op);
         chk("round", rnd_a,   e_rnd);    chk("round_w", rnd_w,   e_rnd);
         chk("we",    we_a,    e_we);     chk("we_w",    we_w,    e_we);
         chk("ready", ready_a, e_ready);  chk("ready_w", ready_w, e_ready);
         chk("dov",   dov_a,   e_dov);    chk("dov_w",   dov_w,   e_dov);
         chk("tag",   tag_a,   e_tag);    chk("tag_w",   tag_w,   e_tag);
         chk("busy",  busy_a,  m_busy);   chk("busy_w",  busy_w,  m_busy);
         chk("dec",   dec_a,   m_dec);    chk("dec_w",   dec_w,   m_dec);
         chk("blk",   blk_a,   m_blk % 256);
         chk("blk_w", blk_w,   m_blk % 4);

         if (rst) begin
            exp_q.delete();
            m_busy = 0; m_wait = 0; m_blk = 0; m_dec = 0; m_ad = 0;
         end else if (!m_busy) begin
            if (start) begin
               m_busy = 1; m_dec = decrypt; m_ad = ad_present; m_blk = 0; m_wait = 0;
               exp_q.push_back('{4'd1, 0, A_NONE});
               add_rounds(1, 11, m_ad ? 4'd2 : 4'd3, m_ad ? A_WAIT_AD : A_WAIT_MSG_CLR);
            end
         end else if (exp_q.size() > 0) begin
            s_cur = exp_q.pop_front();
            case (s_cur.after)
               A_WAIT_AD:      m_wait = 1;
               A_WAIT_AD_INC:  begin m_wait = 1; m_blk++; end
               A_WAIT_MSG_CLR: begin m_wait = 2; m_blk = 0; end
               A_WAIT_MSG_INC: begin m_wait = 2; m_blk++; end
               A_IDLE:         begin m_busy = 0; m_wait = 0; m_blk = 0; end
               default: ;
            endcase
         end else if (m_wait == 1 && di_valid) begin
            m_wait = 0;
            add_rounds(5, 11, di_last ? 4'd5 : 4'd0, di_last ? A_WAIT_MSG_CLR : A_WAIT_AD_INC);
         end else if (m_wait == 2 && di_valid) begin
            m_wait = 0;
            if (di_last) add_rounds(1, 11, 4'd8, A_IDLE);
            else         add_rounds(5, 11, 4'd0, A_WAIT_MSG_INC);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; ad_present = 0; decrypt = 0; di_valid = 0; di_last = 0; rst = 0;
   endtask

   task automatic begin_op(input bit ad, input bit dec);
      tick();
      start = 1; ad_present = ad; decrypt = dec;
   endtask

   // No AD, single message block; optional start pulses during INIT and FINAL.
   task automatic t_no_ad(input bit poke);
      begin_op(0, 1); di_valid = 1; di_last = 1;
      for (int k = 1; k <= 26; k++) begin
         tick();
         start = poke && (k == 5 || k == 20);
         @(negedge clk);
         if (k == 1)  begin chk("noad_op1", op_a, 1); chk("noad_r0", rnd_a, 0); chk("noad_busy", busy_a, 1); end
         if (k == 12) begin chk("noad_op3", op_a, 3); chk("noad_r11", rnd_a, 11); end
         if (k == 13) begin chk("noad_op7", op_a, 7); chk("noad_acc_r", rnd_a, 0); chk("noad_dov", dov_a, 1); end
         if (k == 24) begin chk("noad_op8", op_a, 8); chk("noad_tag", tag_a, 1); end
         if (k == 25) begin chk("noad_idle", busy_a, 0); chk("noad_dec_hold", dec_a, 1); end
      end
      idle_inputs();
   endtask

   task automatic t_two_ad();
      begin_op(1, 0); di_valid = 1; di_last = 0;
      for (int k = 1; k <= 49; k++) begin
         tick();
         start = 0;
         di_last = (k == 21 || k == 37);
         @(negedge clk);
         if (k == 12) chk("ad_op2", op_a, 2);
         if (k == 13) begin chk("ad_op4a", op_a, 4); chk("ad_blk0", blk_a, 0); end
         if (k == 21) begin chk("ad_op4b", op_a, 4); chk("ad_blk1", blk_a, 1); end
         if (k == 28) begin chk("ad_op5", op_a, 5); chk("ad_r11", rnd_a, 11); end
         if (k == 29) begin chk("msg_op6", op_a, 6); chk("msg_blk0", blk_a, 0); chk("msg_r4", rnd_a, 4); end
         if (k == 37) begin chk("msg_op7", op_a, 7); chk("msg_blk1", blk_a, 1); end
         if (k == 48) begin chk("ad_tag", tag_a, 1); chk("ad_op8", op_a, 8); end
         if (k == 49) chk("ad_idle", busy_a, 0);
      end
      idle_inputs();
   endtask

   task automatic t_stall();
      begin_op(0, 0); di_valid = 0; di_last = 1;
      for (int k = 1; k <= 35; k++) begin
         tick();
         start = 0;
         di_valid = (k >= 23);
         @(negedge clk);
         if (k >= 13 && k <= 22) begin
            chk("stall_we", we_a, 0); chk("stall_op", op_a, 0); chk("stall_ready", ready_a, 0);
         end
         if (k == 23) begin chk("stall_acc_op", op_a, 7); chk("stall_dov", dov_a, 1); end
         if (k == 34) chk("stall_tag", tag_a, 1);
      end
      idle_inputs();
   endtask

   task automatic t_reset_mid();
      begin_op(0, 1); di_valid = 1; di_last = 1;
      for (int k = 1; k <= 31; k++) begin
         tick();
         start = (k == 6);
         rst   = (k == 5);
         @(negedge clk);
         if (k == 6) begin
            chk("rst_busy", busy_a, 0); chk("rst_op", op_a, 0); chk("rst_we", we_a, 0);
            chk("rst_round", rnd_a, 0); chk("rst_dec", dec_a, 0); chk("rst_ready", ready_a, 0);
         end
         if (k == 7)  begin chk("restart_op1", op_a, 1); chk("restart_r0", rnd_a, 0); end
         if (k == 30) chk("restart_tag", tag_a, 1);
      end
      idle_inputs();
   endtask

   task automatic t_wrap();
      int wrap_exp[5] = '{0, 1, 2, 3, 0};
      begin_op(0, 0); di_valid = 1; di_last = 0;
      for (int k = 1; k <= 57; k++) begin
         tick();
         start = 0;
         di_last = (k == 45);
         @(negedge clk);
         for (int i = 0; i < 5; i++) begin
            if (k == 13 + 8 * i) begin
               chk("wrap_blk_w", blk_w, wrap_exp[i]);
               chk("wrap_blk", blk_a, i);
               chk("wrap_op", op_a, (i == 4) ? 7 : 6);
            end
         end
         if (k == 56) chk("wrap_tag", tag_w, 1);
      end
      idle_inputs();
   endtask

   task automatic t_random(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         rst        = ($urandom_range(0, 399) == 0);
         start      = ($urandom_range(0, 9) == 0);
         ad_present = $urandom_range(0, 1);
         decrypt    = $urandom_range(0, 1);
         di_valid   = ($urandom_range(0, 3) != 0);
         di_last    = ($urandom_range(0, 2) == 0);
      end
      idle_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle_inputs();
      rst = 1;
      repeat (3) tick();
      rst = 0;
      checking = 1'b1;
      @(negedge clk);
      chk("reset_busy", busy_a, 0);
      chk("reset_op", op_a, 0);
      t_no_ad(0);
      t_no_ad(1);
      t_two_ad();
      t_stall();
      t_reset_mid();
      t_wrap();
      t_random(6000);
      repeat (60) tick();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ascon_aead_sequencer.md
Name: ascon_aead_sequencer

Overview:
- Control FSM that drives the Ascon-AEAD128 single-round datapath (ascon_round_function) one permutation round per cycle.
- Generates the per-cycle operation code, the round index and the state-register write enable.
- Accepts associated-data (AD) and message blocks over a valid/ready stream, emits the processed-block strobe and the tag strobe.
- Sits between the subsystem register/stream front-end and the round-function datapath plus its external state register.

Parameters:
BLOCK_AW, 8, width of the per-phase block counter driven to the datapath.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  begin operation; sampled only in IDLE
ad_present_i  in  1  operation has >=1 AD block; latched at start
decrypt_i  in  1  decrypt mode; latched at start
di_valid_i  in  1  input block valid
di_last_i  in  1  block is last of current phase (AD or MSG)
di_ready_o  out  1  block consumed this cycle
op_o  out  ascon_op_e  operation code to the datapath
round_o  out  ROUND_WIDTH  round index to the datapath
decrypt_o  out  1  latched decrypt flag
di_blk_no_o  out  BLOCK_AW  index of the current block within its phase
state_we_o  out  1  write the datapath state_o into the state register
do_valid_o  out  1  datapath data_o is valid this cycle
tag_valid_o  out  1  datapath tag_o is valid this cycle
busy_o  out  1  operation in progress

Behaviour:
- Clock and reset: one clock clk_i. Reset rst_i is synchronous, active-high. Reset at any point, including mid-permutation, forces IDLE.
- Reset and IDLE outputs: op_o=AsconOp0, round_o=0, state_we_o=0, di_ready_o=0, do_valid_o=0, tag_valid_o=0, busy_o=0, di_blk_no_o=0, decrypt_o=0.
- States:
  - IDLE
  - INIT (12 rounds)
  - WAIT_AD
  - AD (rounds 5..11)
  - WAIT_MSG
  - MSG (rounds 5..11)
  - FINAL (rounds 1..11)
- Round counter: round_o=0..11 for 12-round permutations, 4..11 for 8-round permutations. state_we_o=1 on every round cycle, 0 otherwise.
- IDLE:
  - start_i=1 latches ad_present_i and decrypt_i, sets busy_o, and goes to INIT next cycle. No round executes in the start cycle.
  - start_i is ignored whenever busy_o=1.
- INIT:
  - First cycle: round 0, op=AsconOp1 (load IV).
  - Middle rounds: AsconOp0.
  - Round 11: AsconOp2 if ad_present, else AsconOp3 (key plus domain separation).
  - Next state: WAIT_AD if ad_present, else WAIT_MSG. di_blk_no_o is cleared to 0 on entry.
- WAIT_AD:
  - di_ready_o=di_valid_i. Acceptance executes round 4 with AsconOp4 the same cycle. di_last_i is latched.
  - Next state: AD.
- AD:
  - Rounds 5..11, AsconOp0.
  - Round 11 uses AsconOp5 if the latched last flag is set; the next state is then WAIT_MSG and the counter is cleared.
  - Otherwise, after round 11, go to WAIT_AD and increment di_blk_no_o.
- WAIT_MSG: di_ready_o=di_valid_i. do_valid_o=1 in the acceptance cycle.
  - Not last: round 4, AsconOp6, then MSG.
  - Last: round 0, AsconOp7 (key xor), then FINAL.
- MSG:
  - Rounds 5..11, AsconOp0.
  - Then WAIT_MSG with di_blk_no_o incremented.
- FINAL:
  - Rounds 1..11, AsconOp0.
  - Round 11: AsconOp8 with tag_valid_o=1.
  - Next state: IDLE, busy_o cleared.
- di_ready_o is 0 in every state other than WAIT_AD/WAIT_MSG. No input is consumed during rounds.
- Strobes: do_valid_o and tag_valid_o are single-cycle pulses with no backpressure.
- di_blk_no_o wraps modulo 2^BLOCK_AW.
- The message phase always contains at least one block; padding is done upstream.
- decrypt_o holds its latched value until the next start.

Test Plan:
- Reset mid-run: start, wait 5 cycles, pulse rst_i -> next cycle IDLE: all outputs 0, op_o=AsconOp0, busy_o=0. A subsequent start restarts at INIT round 0.
- No AD, one message block, start at T, di_valid_i held high:
  - AsconOp1 at T+1.
  - AsconOp3 at T+12, round 11.
  - Accept at T+13 with AsconOp7, round 0, do_valid_o=1.
  - tag_valid_o=1 with AsconOp8 at T+24, busy_o=0 at T+25.
- Two AD and two message blocks, inputs always valid:
  - AsconOp2 at T+12.
  - AsconOp4 at T+13 and T+21, with di_blk_no_o=0 then 1.
  - AsconOp5 at T+28.
  - AsconOp6 at T+29, blk 0.
  - AsconOp7 at T+37, blk 1.
  - Tag at T+48.
- Stalled input: in WAIT_MSG hold di_valid_i=0 for 10 cycles -> state_we_o=0 and op_o=AsconOp0 throughout. Accept occurs on the first valid cycle.
- start_i pulsed during INIT and FINAL -> ignored: no sequence restart and identical cycle timing.
- Block counter wrap with BLOCK_AW=2: 5 message blocks -> di_blk_no_o sequence 0,1,2,3,0.
